// File: rtl/rv_fetch_unit.sv
// rv_fetch_unit: RV32 fetch front end with a sync-imem request path, a fetch queue and redirect flush; FETCH_PERF_EN adds perf counters
module rv_fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int FQ_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus4,
  output logic [DATA_W-1:0] if_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_flush
);
  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 2;
  logic [ADDR_W-1:0] pc_q, fl_pc, target;
  logic              fl, pop, push, unused;
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     count, occ;
  logic [ADDR_W-1:0] q_pc  [FQ_DEPTH];
  logic [ADDR_W-1:0] q_pc4 [FQ_DEPTH];
  logic [DATA_W-1:0] q_ins [FQ_DEPTH];
  assign unused      = ^redirect_pc[1:0];
  assign target      = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign imem_addr   = redirect_valid ? target : pc_q;
  assign if_valid    = (count != '0) & ~redirect_valid;
  assign pop         = if_valid & if_ready;
  assign push        = fl & ~redirect_valid;
  // a redirect discards queue and in-flight work, so it sees an empty pipe
  assign occ         = redirect_valid ? '0 : count + CW'(fl) - CW'(pop);
  assign imem_en     = reset & (occ < CW'(FQ_DEPTH));
  assign if_pc       = q_pc[head];
  assign if_pc_plus4 = q_pc4[head];
  assign if_instr    = q_ins[head];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= RESET_PC;
      fl    <= 1'b0;
      fl_pc <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        q_pc[i]  <= '0;
        q_pc4[i] <= '0;
        q_ins[i] <= '0;
      end
    end else begin
      if (imem_en) pc_q <= imem_addr + ADDR_W'(4);
      fl    <= imem_en;
      fl_pc <= imem_addr;
      if (redirect_valid) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          q_pc[tail]  <= fl_pc;
          q_pc4[tail] <= fl_pc + ADDR_W'(4);
          q_ins[tail] <= imem_rdata;
          tail        <= tail + PW'(1);
        end
        if (pop) head <= head + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
`ifdef FETCH_PERF_EN
  logic [31:0] n_fetch, n_stall, n_flush;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_fetch <= '0;
      n_stall <= '0;
      n_flush <= '0;
    end else begin
      n_fetch <= n_fetch + 32'(pop);
      n_stall <= n_stall + 32'(if_valid & ~if_ready);
      n_flush <= n_flush + 32'(redirect_valid);
    end
  end
  assign perf_fetched = n_fetch;
  assign perf_stall   = n_stall;
  assign perf_flush   = n_flush;
`else
  assign perf_fetched = '0;
  assign perf_stall   = '0;
  assign perf_flush   = '0;
`endif
endmodule
